hbs_grant_scheduler: RTL
========================

// Module: hbs_grant_scheduler
// PURPOSE
//  Arbiter that shares one pipelined high-bit search engine between up to N_REQ requesters.
//  Each request pulse is latched into a pending mask. The block snapshots the mask, waits out the
//  search pipeline, then offers the highest-index pending requester on a valid/ready grant port.
//  Fixed priority: the highest index wins. Sits between the request sources and the shared consumer.
// PARAMETERS
//  N_REQ      16              number of requesters, must be >= 2
//  IDX_W      $clog2(N_REQ)   width of grant_idx
//  SEARCH_LAT $clog2(N_REQ)   search pipeline depth in cycles, must be >= 1
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  req_in       in   N_REQ  request pulses; bit k=1 for one or more cycles requests service for k
//  enable       in   1      1 = new searches may start
//  grant_ready  in   1      consumer accepts the current grant
//  grant_valid  out  1      grant_idx is valid and held
//  grant_idx    out  IDX_W  index of the granted requester
//  pending      out  N_REQ  registered pending mask
//  busy         out  1      1 while state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; pending, snapshot, counter, grant_valid, grant_idx and busy
//   are all 0. Outputs drop immediately, without waiting for a clock edge.
//  Pending mask, every edge: pending <= (pending & ~clr) | req_in.
//   clr = onehot(grant_idx) when (grant_valid & grant_ready), else 0.
//   If a bit is set and cleared in the same edge, the set wins and the bit stays pending.
//  FSM states: IDLE, SEARCH, OFFER.
//   IDLE -> SEARCH when enable=1 and pending!=0.
//     On that edge: snapshot <= pending, cnt <= 0.
//     IDLE uses the registered pending value only. A req_in bit takes effect one edge later.
//   SEARCH: cnt increments each edge.
//     -> OFFER on the edge where cnt==SEARCH_LAT-1, so SEARCH lasts exactly SEARCH_LAT cycles.
//     The edge entering OFFER loads grant_idx = index of the highest set bit of snapshot
//     and sets grant_valid=1.
//   OFFER: grant_valid and grant_idx are held stable until grant_ready=1.
//     -> IDLE on the handshake edge; grant_valid <= 0 on that edge.
//  Latency, N_REQ=16, SEARCH_LAT=4, idle block, req_in sampled at edge E0:
//   SEARCH is entered at E1 and grant_valid is high after E5.
//   Back-to-back grants with grant_ready tied to 1: handshake edges are 6 cycles apart
//   (1 IDLE + SEARCH_LAT SEARCH + 1 OFFER).
//  No preemption: requests that arrive during SEARCH or OFFER never change the current grant;
//   they are only picked up by the next snapshot.
//  enable=0 only blocks IDLE->SEARCH. A search or offer already in progress completes normally.
//  grant_idx holds its last value while grant_valid=0 and is a don't-care for consumers.
//  Snapshot bits above the granted one cannot exist. Bits below it stay in pending for later rounds.
//  Width rules: IDX_W bits cover 0..N_REQ-1. For non-power-of-2 N_REQ the search pads the mask
//   with zeros up to 2**IDX_W bits.
// TESTING
//  T1 reset: hold rst_n=0 with req_in=all ones
//     -> grant_valid=0, pending=0, busy=0; no activity for 3 cycles after release while req_in=0.
//  T2 single request: req_in=16'h0020 for 1 cycle at E0, grant_ready=1
//     -> grant_valid high after E5 with grant_idx=5; pending[5]=0 after the handshake; busy=0 after it.
//  T3 priority order: req_in=16'h8421 pulse, grant_ready=1
//     -> grants 15, 10, 5, 0 in that order, handshake edges 6 cycles apart, pending=0 at the end.
//  T4 backpressure: grant idx 5 offered, grant_ready=0 for 10 cycles, req_in bit 12 pulsed mid-offer
//     -> grant_idx stays 5 and grant_valid stays 1; after ready, the next grant is 12.
//  T5 re-request: pulse req_in bit 7 on the same edge as the handshake for idx 7
//     -> pending[7] stays 1 and idx 7 is granted again 6 cycles later.
//  T6 enable and async reset: enable=0 with pending=16'h0003 -> no grant for 20 cycles.
//     Then enable=1, and rst_n=0 asserted mid-OFFER between edges
//     -> grant_valid=0 and pending=0 immediately, before the next edge.

Source files
------------

// File: rtl/hbs_grant_scheduler.sv
// Fixed-priority grant scheduler: latches request pulses into a pending mask, snapshots it,
// waits out the search pipeline latency and offers the highest-index requester on a grant port.
module hbs_grant_scheduler #(
  parameter int N_REQ      = 16,
  parameter int IDX_W      = $clog2(N_REQ),
  parameter int SEARCH_LAT = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic             enable,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] pending,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  localparam int PAD_W = 1 << IDX_W;
  localparam int CNT_W = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    OFFER  = 2'd2
  } state_t;

  state_t             state;
  logic [N_REQ-1:0]   snapshot;
  logic [CNT_W-1:0]   cnt;
  logic [N_REQ-1:0]   clr;
  logic [PAD_W-1:0]   snap_pad;

  // Highest set bit of the zero-padded mask; later (higher) hits overwrite earlier ones.
  function automatic logic [IDX_W-1:0] high_bit(input logic [PAD_W-1:0] m);
    high_bit = '0;
    for (int i = 0; i < PAD_W; i++) begin
      if (m[i]) high_bit = IDX_W'(i);
    end
  endfunction

  assign snap_pad  = PAD_W'(snapshot);
  assign fsm_state = state;

  // Grant handshake: a transfer happens on a rising edge where grant_valid && grant_ready.
  // Once grant_valid rises, grant_valid and grant_idx stay fixed until that transfer.
  always_comb begin
    clr = '0;
    if (grant_valid && grant_ready) clr = N_REQ'(1) << grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= '0;
      snapshot    <= '0;
      cnt         <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      busy        <= 1'b0;
    end else begin
      // A re-request on the handshake edge wins over the clear.
      pending <= (pending & ~clr) | req_in;
      case (state)
        IDLE: begin
          if (enable && (pending != '0)) begin
            state    <= SEARCH;
            snapshot <= pending;
            cnt      <= '0;
            busy     <= 1'b1;
          end
        end
        SEARCH: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(SEARCH_LAT - 1)) begin
            state       <= OFFER;
            grant_valid <= 1'b1;
            grant_idx   <= high_bit(snap_pad);
          end
        end
        OFFER: begin
          if (grant_ready) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
